alu_share_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `alu_32bit` instance between two independent requesters. Each requester presents an ALU operation (control, source select, operands) over a valid/ready handshake. The block latches the winning request, runs it through the internal ALU, and returns a registered result, zero flag and error flag over a per-port response handshake. It sits between the two issue paths and the shared ALU datapath.

---
 rtl/alu_share_arbiter.sv | 156 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares a single 32-bit ALU between two requesters.
// Each request is latched, executed for one cycle, then held as a response.

module alu_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  ctrl,
  output logic [31:0] result,
  output logic        z,
  output logic        err
);

  always_comb begin
    result = '0;
    err    = 1'b0;
    case (ctrl)
      3'b000:  result = a + b;
      3'b001:  result = a - b;
      3'b010:  result = a & b;
      3'b011:  result = a | b;
      3'b101:  result = {31'd0, $signed(a) < $signed(b)};
      default: err = 1'b1;
    endcase
    // An illegal code reports Z=0 even though the result is zero
    z = !err && (result == 32'd0);
  end

endmodule

module alu_share_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid0,
  input  logic        req_valid1,
  output logic        req_ready0,
  output logic        req_ready1,
  input  logic        req_alusrc0,
  input  logic        req_alusrc1,
  input  logic [2:0]  req_aluctrl0,
  input  logic [2:0]  req_aluctrl1,
  input  logic [31:0] req_rd1_0,
  input  logic [31:0] req_rd1_1,
  input  logic [31:0] req_rd2_0,
  input  logic [31:0] req_rd2_1,
  input  logic [31:0] req_imm0,
  input  logic [31:0] req_imm1,
  output logic        resp_valid0,
  output logic        resp_valid1,
  input  logic        resp_ready0,
  input  logic        resp_ready1,
  output logic [31:0] resp_result,
  output logic        resp_z,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, next_state;
  logic        ptr;
  logic        owner;
  logic        op_alusrc;
  logic [2:0]  op_aluctrl;
  logic [31:0] op_rd1, op_rd2, op_imm;
  logic        grant0, grant1;
  logic        resp_done;
  logic [31:0] alu_result;
  logic        alu_z, alu_err;

  alu_32bit u_alu (
    .a      (op_rd1),
    .b      (op_alusrc ? op_imm : op_rd2),
    .ctrl   (op_aluctrl),
    .result (alu_result),
    .z      (alu_z),
    .err    (alu_err)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant0 || grant1) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (resp_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Pointer port has priority; the other port only wins when the pointer port is idle
  always_comb begin
    grant0      = 1'b0;
    grant1      = 1'b0;
    resp_valid0 = 1'b0;
    resp_valid1 = 1'b0;
    resp_done   = 1'b0;
    if (state == IDLE) begin
      if (ptr == 1'b0) begin
        grant0 = req_valid0;
        grant1 = !req_valid0 && req_valid1;
      end else begin
        grant1 = req_valid1;
        grant0 = !req_valid1 && req_valid0;
      end
    end
    if (state == RESP) begin
      resp_valid0 = (owner == 1'b0);
      resp_valid1 = (owner == 1'b1);
      resp_done   = owner ? resp_ready1 : resp_ready0;
    end
  end

  assign req_ready0 = grant0;
  assign req_ready1 = grant1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= 1'b0;
      owner       <= 1'b0;
      op_alusrc   <= 1'b0;
      op_aluctrl  <= '0;
      op_rd1      <= '0;
      op_rd2      <= '0;
      op_imm      <= '0;
      resp_result <= '0;
      resp_z      <= 1'b0;
      resp_err    <= 1'b0;
    end else begin
      if (grant0) begin
        owner      <= 1'b0;
        op_alusrc  <= req_alusrc0;
        op_aluctrl <= req_aluctrl0;
        op_rd1     <= req_rd1_0;
        op_rd2     <= req_rd2_0;
        op_imm     <= req_imm0;
      end else if (grant1) begin
        owner      <= 1'b1;
        op_alusrc  <= req_alusrc1;
        op_aluctrl <= req_aluctrl1;
        op_rd1     <= req_rd1_1;
        op_rd2     <= req_rd2_1;
        op_imm     <= req_imm1;
      end
      if (state == EXEC) begin
        resp_result <= alu_result;
        resp_z      <= alu_z;
        resp_err    <= alu_err;
      end
      if (resp_done) ptr <= ~owner;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter: single-port ops, contention,
// response stall, illegal code and reset while an operation is in flight.

module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid0, req_valid1;
  logic        req_ready0, req_ready1;
  logic        req_alusrc0, req_alusrc1;
  logic [2:0]  req_aluctrl0, req_aluctrl1;
  logic [31:0] req_rd1_0, req_rd1_1, req_rd2_0, req_rd2_1, req_imm0, req_imm1;
  logic        resp_valid0, resp_valid1;
  logic        resp_ready0, resp_ready1;
  logic [31:0] resp_result;
  logic        resp_z, resp_err;

  int checks   = 0;
  int failures = 0;

  alu_share_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid0   (req_valid0),
    .req_valid1   (req_valid1),
    .req_ready0   (req_ready0),
    .req_ready1   (req_ready1),
    .req_alusrc0  (req_alusrc0),
    .req_alusrc1  (req_alusrc1),
    .req_aluctrl0 (req_aluctrl0),
    .req_aluctrl1 (req_aluctrl1),
    .req_rd1_0    (req_rd1_0),
    .req_rd1_1    (req_rd1_1),
    .req_rd2_0    (req_rd2_0),
    .req_rd2_1    (req_rd2_1),
    .req_imm0     (req_imm0),
    .req_imm1     (req_imm1),
    .resp_valid0  (resp_valid0),
    .resp_valid1  (resp_valid1),
    .resp_ready0  (resp_ready0),
    .resp_ready1  (resp_ready1),
    .resp_result  (resp_result),
    .resp_z       (resp_z),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit port, input bit valid, input logic [2:0] ctrl, input bit src,
                               input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm);
    if (port == 1'b0) begin
      req_valid0 = valid; req_aluctrl0 = ctrl; req_alusrc0 = src;
      req_rd1_0 = rd1; req_rd2_0 = rd2; req_imm0 = imm;
    end else begin
      req_valid1 = valid; req_aluctrl1 = ctrl; req_alusrc1 = src;
      req_rd1_1 = rd1; req_rd2_1 = rd2; req_imm1 = imm;
    end
  endtask

  // One complete transaction on a single port, with the other port idle.
  task automatic runOp(input string tag, input bit port, input logic [2:0] ctrl, input bit src,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic [31:0] exp_result, input bit exp_z, input bit exp_err);
    applyStimulus(port, 1'b1, ctrl, src, rd1, rd2, imm);
    #1;
    checkOutput({tag, " ready"}, {30'd0, req_ready1, req_ready0}, port ? 32'd2 : 32'd1);
    tick();
    applyStimulus(port, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    checkOutput({tag, " exec no resp"}, {30'd0, resp_valid1, resp_valid0}, 32'd0);
    tick();
    checkOutput({tag, " resp_valid"}, {30'd0, resp_valid1, resp_valid0}, port ? 32'd2 : 32'd1);
    checkOutput({tag, " result"}, resp_result, exp_result);
    checkOutput({tag, " z/err"}, {30'd0, resp_z, resp_err}, {30'd0, exp_z, exp_err});
    if (port) resp_ready1 = 1'b1; else resp_ready0 = 1'b1;
    tick();
    resp_ready0 = 1'b0;
    resp_ready1 = 1'b0;
    checkOutput({tag, " done"}, {30'd0, resp_valid1, resp_valid0}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    resp_ready0 = 1'b0;
    resp_ready1 = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    checkOutput("reset resp_valid", {30'd0, resp_valid1, resp_valid0}, 32'd0);
    checkOutput("reset result", resp_result, 32'd0);
    checkOutput("reset z/err", {30'd0, resp_z, resp_err}, 32'd0);
    checkOutput("reset ready", {30'd0, req_ready1, req_ready0}, 32'd0);

    runOp("add0", 1'b0, 3'b000, 1'b0, 32'd2, 32'd5, 32'd0, 32'd7, 1'b0, 1'b0);
    runOp("sub_zero", 1'b1, 3'b001, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0);
    runOp("sub", 1'b1, 3'b001, 1'b0, 32'd5, 32'd2, 32'd0, 32'd3, 1'b0, 1'b0);
    runOp("slt", 1'b1, 3'b101, 1'b0, 32'd2, 32'd5, 32'd0, 32'd1, 1'b0, 1'b0);
    runOp("slt_signed", 1'b1, 3'b101, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1, 1'b0, 1'b0);
    runOp("slt_false", 1'b1, 3'b101, 1'b0, 32'd5, 32'd2, 32'd0, 32'd0, 1'b1, 1'b0);
    runOp("imm_add", 1'b0, 3'b000, 1'b1, 32'd1, 32'hDEAD_BEEF, 32'h0000_7FFF, 32'h0000_8000, 1'b0, 1'b0);
    runOp("or", 1'b0, 3'b011, 1'b0, 32'd2, 32'd5, 32'd0, 32'd7, 1'b0, 1'b0);
    runOp("and", 1'b0, 3'b010, 1'b0, 32'd2, 32'd5, 32'd0, 32'd0, 1'b1, 1'b0);
    runOp("add_wrap", 1'b0, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0);

    // Contention: both ports hold valid; responses accepted on arrival.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0);
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 32'd3, 32'd3, 32'd0);
    resp_ready0 = 1'b1;
    resp_ready1 = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr grant %0d", i), {30'd0, req_ready1, req_ready0}, (i % 2) ? 32'd2 : 32'd1);
      tick();
      checkOutput($sformatf("rr exec ready %0d", i), {30'd0, req_ready1, req_ready0}, 32'd0);
      tick();
      checkOutput($sformatf("rr resp port %0d", i), {30'd0, resp_valid1, resp_valid0}, (i % 2) ? 32'd2 : 32'd1);
      checkOutput($sformatf("rr result %0d", i), resp_result, (i % 2) ? 32'd6 : 32'd2);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    resp_ready0 = 1'b0;
    resp_ready1 = 1'b0;

    // Stall: port 0 response held for 4 cycles while port 1 waits.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0, 32'd2, 32'd5, 32'd0);
    applyStimulus(1'b1, 1'b1, 3'b001, 1'b0, 32'd9, 32'd4, 32'd0);
    #1;
    checkOutput("stall grant0", {30'd0, req_ready1, req_ready0}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("stall valid %0d", i), {30'd0, resp_valid1, resp_valid0}, 32'd1);
      checkOutput($sformatf("stall result %0d", i), resp_result, 32'd7);
      checkOutput($sformatf("stall ready1 %0d", i), {31'd0, req_ready1}, 32'd0);
      resp_ready1 = 1'b1;
      tick();
    end
    resp_ready1 = 1'b0;
    resp_ready0 = 1'b1;
    tick();
    resp_ready0 = 1'b0;
    checkOutput("stall then grant1", {30'd0, req_ready1, req_ready0}, 32'd2);
    tick();
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("stall p1 resp", {30'd0, resp_valid1, resp_valid0}, 32'd2);
    checkOutput("stall p1 result", resp_result, 32'd5);
    resp_ready1 = 1'b1;
    tick();
    resp_ready1 = 1'b0;

    runOp("illegal111", 1'b0, 3'b111, 1'b0, 32'd2, 32'd5, 32'd0, 32'd0, 1'b0, 1'b1);
    runOp("illegal100", 1'b1, 3'b100, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    runOp("illegal110", 1'b0, 3'b110, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

    // Reset in EXEC: pointer is at port 1 here, reset must return it to port 0.
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 32'd4, 32'd4, 32'd0);
    #1;
    checkOutput("rst_exec grant1", {30'd0, req_ready1, req_ready0}, 32'd2);
    tick();
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    resp_ready1 = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rst_exec no resp %0d", i), {30'd0, resp_valid1, resp_valid0}, 32'd0);
      checkOutput($sformatf("rst_exec regs %0d", i), resp_result, 32'd0);
      tick();
    end
    resp_ready1 = 1'b0;
    applyStimulus(1'b0, 1'b1, 3'b000, 1'b0, 32'd10, 32'd20, 32'd0);
    applyStimulus(1'b1, 1'b1, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0);
    #1;
    checkOutput("rst_exec ptr0", {30'd0, req_ready1, req_ready0}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b000, 1'b0, 32'd0, 32'd0, 32'd0);
    tick();
    checkOutput("rst_exec after resp", {30'd0, resp_valid1, resp_valid0}, 32'd1);
    checkOutput("rst_exec after result", resp_result, 32'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
